// File: rtl/share_recombiner.sv
// share_recombiner: XOR-recombines a frame of Boolean shares into one value,
// flags frames whose length differs from NUM_SHARES, and presents the result
// on a valid/ready output that blocks new shares until it is taken.
module share_recombiner #(
  parameter int NUM_SHARES = 8,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_err
);

  // Counter must hold NUM_SHARES itself so it can saturate once a frame overruns.
  localparam int CW = $clog2(NUM_SHARES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_SHARES - 1);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,  // collecting shares; count 0 here means idle
    DRAIN = 2'd1,  // frame overran: swallow beats until s_last
    HOLD  = 2'd2   // result presented, waiting for m_ready
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             err, err_nxt;
  logic             run;
  logic             beat;

  // s_ready stays low during reset and rises at the first edge after release.
  assign s_ready = run && (state != HOLD);
  assign beat    = s_valid && s_ready;

  // Gate the outputs so no share or partial XOR leaks out while m_valid is low.
  assign m_valid = (state == HOLD);
  assign m_data  = m_valid ? acc : '0;
  assign m_err   = m_valid & err;

  // Run flag: marks that at least one clock edge has passed since reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with <= so every register samples
    // pre-edge values regardless of block ordering.
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Accumulator, share counter and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      err <= err_nxt;
    end
  end

  // Next-state and datapath update rules.
  always_comb begin
    // NOTE: every target gets a hold-value default first, so no path through
    // the case leaves one unassigned and no latch is inferred.
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    err_nxt   = err;
    case (state)
      ACCUM: begin
        if (beat) begin
          acc_nxt = acc ^ s_data;
          cnt_nxt = cnt + CW'(1);
          if (s_last) begin
            err_nxt   = (cnt != LAST_IDX);
            state_nxt = HOLD;
          end else if (cnt == LAST_IDX) begin
            // Last legal share arrived without s_last: result is final, rest is dropped.
            err_nxt   = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Accumulator and saturated counter are frozen here.
        if (beat && s_last) state_nxt = HOLD;
      end
      HOLD: begin
        if (m_ready) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

endmodule

// File: tb/tb_share_recombiner.sv
// tb_share_recombiner: directed frames plus randomized frames with random gaps
// and random m_ready, checked against a frame-level XOR/length model.
module tb_share_recombiner;

  localparam int NS = 8;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic         m_err;

  share_recombiner #(.NUM_SHARES(NS), .WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .s_last (s_last),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_err  (m_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         err;
  } out_t;

  out_t         exp_q[$];
  logic [W-1:0] frame_q[$];
  int           mr_mode = 2;   // 0 random, 1 hold low, 2 hold high
  int           n_out   = 0;
  int           n_exp   = 0;

  // Expected result of a frame: XOR of the first NS shares, error unless exactly NS.
  function automatic out_t model(input int n);
    out_t r;
    r.data = '0;
    for (int i = 0; i < n && i < NS; i++) r.data ^= frame_q[i];
    r.err = (n != NS);
    return r;
  endfunction

  // Output side: drive m_ready each cycle and score completed handshakes.
  initial begin
    forever begin
      @(negedge clk);
      case (mr_mode)
        0:       m_ready = 1'($urandom_range(0, 1));
        1:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
      if (!m_valid) begin
        check("idle_m_data", 32'(m_data), 0);
      end else if (rst_n && m_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(m_data), 32'hDEAD);
        end else begin
          check("m_data", 32'(m_data), 32'(exp_q[0].data));
          check("m_err", 32'(m_err), 32'(exp_q[0].err));
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Present one beat after an optional idle gap; returns cycles spent stalled.
  task automatic send_beat(input logic [W-1:0] d, input logic last, input int gap_max,
                           output int stalls);
    repeat ($urandom_range(0, gap_max)) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_data  = W'($urandom);
      s_last  = 1'($urandom);
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    stalls  = 0;
    while (!s_ready && stalls < 200) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 200) check("beat_timeout", 0, 1);
    @(posedge clk);
  endtask

  // Send frame_q with s_last on its final entry; returns stalls after the first beat.
  task automatic send_frame(input int gap_max, output int stall_sum);
    int st;
    int n;
    n = frame_q.size();
    stall_sum = 0;
    for (int i = 0; i < n; i++) begin
      send_beat(frame_q[i], (i == n - 1), gap_max, st);
      if (i > 0) stall_sum += st;
    end
    exp_q.push_back(model(n));
    n_exp++;
    @(negedge clk);
    check("latency_m_valid", 32'(m_valid), 1);
    check("hold_s_ready", 32'(s_ready), 0);
    s_valid = 1'b0;
  endtask

  task automatic load_nominal();
    frame_q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hC0};
  endtask

  task automatic drain_outputs();
    int guard;
    guard = 0;
    mr_mode = 2;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int st;
    int n;

    // Reset state.
    #1;
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_err", 32'(m_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("release_s_ready_before_edge", 32'(s_ready), 0);
    @(negedge clk);
    check("release_s_ready", 32'(s_ready), 1);

    // Nominal frame.
    mr_mode = 2;
    load_nominal();
    send_frame(0, st);
    drain_outputs();

    // Short frame.
    frame_q = '{8'h01, 8'h02, 8'h04};
    send_frame(0, st);
    check("short_model_data", 32'(model(3).data), 32'h07);
    drain_outputs();

    // Long frame: two extra beats dropped, never stalled.
    load_nominal();
    frame_q.push_back(8'hFF);
    frame_q.push_back(8'hAA);
    send_frame(0, st);
    check("long_no_stall", 32'(st), 0);
    drain_outputs();

    // Backpressure: output held steady for 5 cycles, then cleared.
    mr_mode = 1;
    load_nominal();
    send_frame(0, st);
    repeat (5) begin
      @(negedge clk);
      check("bp_m_valid", 32'(m_valid), 1);
      check("bp_m_data", 32'(m_data), 32'h30);
      check("bp_s_ready", 32'(s_ready), 0);
    end
    mr_mode = 2;
    repeat (2) @(negedge clk);
    check("bp_after_m_valid", 32'(m_valid), 0);
    check("bp_after_m_data", 32'(m_data), 0);
    check("bp_after_s_ready", 32'(s_ready), 1);
    drain_outputs();

    // Reset mid-frame, then a full frame gives exactly one output.
    load_nominal();
    for (int i = 0; i < 4; i++) send_beat(frame_q[i], 1'b0, 0, st);
    @(negedge clk);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    check("midrst_s_ready", 32'(s_ready), 0);
    check("midrst_m_valid", 32'(m_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(0, st);
    drain_outputs();

    // Reset while holding a result: that result must never appear.
    mr_mode = 1;
    frame_q = '{8'h55, 8'hAA};
    send_frame(0, st);
    @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    n_exp--;
    #1;
    check("holdrst_m_valid", 32'(m_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drain_outputs();

    // Back-to-back frames with s_valid held high.
    load_nominal();
    send_frame(0, st);
    s_valid = 1'b1;
    send_frame(0, st);
    drain_outputs();

    // Randomized frames, random gaps and random m_ready.
    mr_mode = 0;
    for (int f = 0; f < 40; f++) begin
      n = ($urandom_range(0, 1) == 1) ? NS : $urandom_range(1, NS + 4);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(W'($urandom));
      send_frame(2, st);
    end
    drain_outputs();

    repeat (3) @(negedge clk);
    check("output_count", 32'(n_out), 32'(n_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got=timeout expected=done");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/share_recombiner.md
SHARE_RECOMBINER -- requirements
Module: share_recombiner

Interface
REQ-001 SHALL have parameter NUM_SHARES, default 8, number of Boolean (XOR) shares per masked value; legal range 2..16.
REQ-002 SHALL have parameter WIDTH, default 8, bit width of each share and of the recombined value.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port s_valid  input  1  share beat valid.
REQ-006 SHALL have port s_ready  output  1  block accepts share beat.
REQ-007 SHALL have port s_data  input  WIDTH  one share.
REQ-008 SHALL have port s_last  input  1  marks final share of a frame.
REQ-009 SHALL have port m_valid  output  1  recombined value valid.
REQ-010 SHALL have port m_ready  input  1  downstream accepts value.
REQ-011 SHALL have port m_data  output  WIDTH  XOR of all accepted shares in the frame.
REQ-012 SHALL have port m_err  output  1  frame length error, qualified by m_valid.

Function
REQ-013 SHALL count a share beat as accepted only in a cycle with s_valid=1 and s_ready=1.
REQ-014 SHALL implement states ACCUM, DRAIN and HOLD, with ACCUM and share count 0 as idle.
REQ-015 SHALL drive s_ready=1 in ACCUM and DRAIN, and s_ready=0 in HOLD.
REQ-016 SHALL, in ACCUM, XOR each accepted s_data into a WIDTH-bit accumulator and increment a share counter.
REQ-017 SHALL, on an accepted beat with s_last=1 that is share NUM_SHARES-1 (counting from 0), go to HOLD with m_err=0.
REQ-018 SHALL, on an accepted beat with s_last=1 that is an earlier share, go to HOLD with m_err=1 and m_data equal to the partial XOR.
REQ-019 SHALL, on an accepted share NUM_SHARES-1 with s_last=0, latch m_err=1, freeze the accumulator and go to DRAIN.
REQ-020 SHALL, in DRAIN, accept and discard beats without changing the accumulator, and go to HOLD on the accepted beat with s_last=1.
REQ-021 SHALL drive m_valid=1 only in HOLD, with m_data and m_err stable until the handshake completes.
REQ-022 SHALL assert m_valid in the first cycle after the closing beat is accepted (latency 1 cycle).
REQ-023 SHALL, on m_valid=1 and m_ready=1, return to ACCUM, clear the accumulator, share counter and m_err, and accept no share in that cycle.
REQ-024 SHALL clear the accumulator and m_data to zero after each handshake, so no share or partial XOR remains visible on m_data when m_valid=0.
REQ-025 SHALL keep the share counter from wrapping; the counter saturates in DRAIN.
REQ-026 SHALL ignore s_data and s_last whenever s_valid=0 or s_ready=0.

Reset
REQ-027 SHALL, while rst_n=0, force state ACCUM, counter 0, accumulator 0, m_valid=0, m_data=0, m_err=0 and s_ready=0.
REQ-028 SHALL drive s_ready=1 from the first clock edge after rst_n is released.
REQ-029 SHALL discard any partial frame or pending output when reset is asserted mid-frame or in HOLD, with no output beat for that frame after release.

Verification
REQ-030 SHALL pass the nominal frame: shares 0x12,0x34,0x56,0x78,0x9A,0xBC,0xDE,0xC0 with s_last on the 8th -> m_valid on the next cycle, m_data=0x30, m_err=0.
REQ-031 SHALL pass the short frame: 0x01,0x02,0x04 with s_last on the 3rd -> m_data=0x07, m_err=1.
REQ-032 SHALL pass the long frame: the 8 shares of REQ-030 without s_last, then 0xFF and then 0xAA with s_last -> m_data=0x30, m_err=1, extra beats dropped, s_ready=1 throughout.
REQ-033 SHALL pass backpressure: m_ready=0 for 5 cycles after REQ-030 completes -> m_valid held, m_data=0x30 stable, s_ready=0; after handshake m_data=0x00 and s_ready=1.
REQ-034 SHALL pass reset mid-frame: rst_n low after 4 shares of REQ-030, then the full REQ-030 frame -> single output m_data=0x30, m_err=0.
REQ-035 SHALL pass back-to-back frames: two REQ-030 frames with s_valid held high -> two outputs of 0x30, each preceded by at least one s_ready=0 cycle.
